// File: rtl/uart_echo_fifo.sv
// uart_echo_fifo
// Receives characters from a UART receiver (one per rising edge of RX_STATUS),
// applies a MODE-selected transform at enqueue time, buffers them in a small
// circular FIFO and re-issues them to a UART transmitter as one-cycle TX_EN
// strobes whenever the transmitter reports idle.
//
// Optional feature: define UART_ECHO_OVF_CNT_EN to add the OVF_CNT output, an
// 8-bit saturating count of dropped characters.  Without the macro the port
// and its counter are absent and everything else behaves identically.
module uart_echo_fifo #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4
) (
    input  logic                     sysclk,
    input  logic                     reset_n,
    input  logic                     RX_STATUS,
    input  logic [DATA_W-1:0]        RX_DATA,
    input  logic                     TX_STATUS,
    input  logic [1:0]               MODE,
    input  logic                     CLR_OVF,
    output logic [DATA_W-1:0]        TX_DATA,
    output logic                     TX_EN,
    output logic [$clog2(DEPTH):0]   FIFO_COUNT,
    output logic                     OVERFLOW
`ifdef UART_ECHO_OVF_CNT_EN
    ,
    output logic [7:0]               OVF_CNT
`endif
);

    // Pointer width; DEPTH is a power of two so pointers wrap naturally.
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // Occupancy width; one extra bit so that "full" (== DEPTH) is representable.
    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic                 rx_q_reg;
    logic [AW-1:0]        wr_ptr_reg;
    logic [AW-1:0]        wr_ptr_next;
    logic [AW-1:0]        rd_ptr_reg;
    logic [AW-1:0]        rd_ptr_next;
    logic [CW-1:0]        count_reg;
    logic [CW-1:0]        count_next;
    logic [DATA_W-1:0]    tx_data_reg;
    logic [DATA_W-1:0]    tx_data_next;
    logic                 tx_en_reg;
    logic                 tx_en_next;
    logic                 overflow_reg;
    logic                 overflow_next;

    // Character storage; no reset needed since occupancy gates every read.
    logic [DATA_W-1:0]    mem [DEPTH];

    // ------------------------------------------------------------------
    // Control decode
    // ------------------------------------------------------------------
    logic                 push;
    logic                 pop;
    logic                 full;
    logic                 empty;
    logic                 wr_en;
    logic                 drop;

    // A new character is announced by a rising edge of the receiver's valid level.
    assign push  = RX_STATUS & ~rx_q_reg;
    assign full  = (count_reg == FULL_COUNT);
    assign empty = (count_reg == '0);
    // Never pop while the previous strobe is still high: guarantees a two-cycle
    // minimum spacing between TX_EN pulses.
    assign pop   = ~empty & TX_STATUS & ~tx_en_reg;
    // When full, a write is only safe if the head leaves in the same cycle.
    assign wr_en = push & (~full | pop);
    assign drop  = push & full & ~pop;

    // ------------------------------------------------------------------
    // Character transform, applied at enqueue time so later MODE changes do
    // not affect characters already queued.
    // ------------------------------------------------------------------
    logic [DATA_W-1:0]    rx_rev;
    logic [DATA_W-1:0]    xform_data;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_W; gi++) begin : g_rev
            assign rx_rev[gi] = RX_DATA[DATA_W-1-gi];
        end
    endgenerate

    // Select the stored character according to MODE.
    always_comb begin
        xform_data = RX_DATA;
        case (MODE)
            2'd0:    xform_data = RX_DATA;
            2'd1:    xform_data = RX_DATA[DATA_W-1] ? ~RX_DATA : RX_DATA;
            2'd2:    xform_data = ~RX_DATA;
            2'd3:    xform_data = rx_rev;
            default: xform_data = RX_DATA;
        endcase
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------

    // Pointer, occupancy and transmit-register updates.
    always_comb begin
        wr_ptr_next  = wr_ptr_reg;
        rd_ptr_next  = rd_ptr_reg;
        count_next   = count_reg;
        tx_data_next = tx_data_reg;
        tx_en_next   = 1'b0;

        if (wr_en) begin
            wr_ptr_next = wr_ptr_reg + AW'(1);
        end

        if (pop) begin
            rd_ptr_next  = rd_ptr_reg + AW'(1);
            tx_data_next = mem[rd_ptr_reg];
            tx_en_next   = 1'b1;
        end

        case ({wr_en, pop})
            2'b10:   count_next = count_reg + CW'(1);
            2'b01:   count_next = count_reg - CW'(1);
            default: count_next = count_reg;
        endcase
    end

    // Sticky overflow: a drop sets it and wins over a simultaneous clear.
    always_comb begin
        overflow_next = overflow_reg;
        if (drop) begin
            overflow_next = 1'b1;
        end else if (CLR_OVF) begin
            overflow_next = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------

    // Control and output registers with asynchronous active-low reset.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            rx_q_reg     <= 1'b0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
            tx_data_reg  <= '0;
            tx_en_reg    <= 1'b0;
            overflow_reg <= 1'b0;
        end else begin
            rx_q_reg     <= RX_STATUS;
            wr_ptr_reg   <= wr_ptr_next;
            rd_ptr_reg   <= rd_ptr_next;
            count_reg    <= count_next;
            tx_data_reg  <= tx_data_next;
            tx_en_reg    <= tx_en_next;
            overflow_reg <= overflow_next;
        end
    end

    // FIFO storage write; when full with a coincident pop the write lands in
    // the slot being read this same edge, which sees the old contents.
    always_ff @(posedge sysclk) begin
        if (wr_en) begin
            mem[wr_ptr_reg] <= xform_data;
        end
    end

`ifdef UART_ECHO_OVF_CNT_EN
    logic [7:0] ovf_cnt_reg;
    logic [7:0] ovf_cnt_next;

    // Saturating drop counter; an increment coinciding with a clear restarts at 1.
    always_comb begin
        ovf_cnt_next = ovf_cnt_reg;
        if (drop) begin
            if (CLR_OVF) begin
                ovf_cnt_next = 8'd1;
            end else if (ovf_cnt_reg != 8'hFF) begin
                ovf_cnt_next = ovf_cnt_reg + 8'd1;
            end
        end else if (CLR_OVF) begin
            ovf_cnt_next = 8'd0;
        end
    end

    // Drop counter register.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            ovf_cnt_reg <= 8'd0;
        end else begin
            ovf_cnt_reg <= ovf_cnt_next;
        end
    end

    assign OVF_CNT = ovf_cnt_reg;
`endif

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign TX_DATA    = tx_data_reg;
    assign TX_EN      = tx_en_reg;
    assign FIFO_COUNT = count_reg;
    assign OVERFLOW   = overflow_reg;

endmodule

// File: tb/tb_uart_echo_fifo.sv
// tb_uart_echo_fifo
// Directed bench for uart_echo_fifo (DATA_W=8, DEPTH=4).  Inputs change and
// outputs are sampled 1 ns after the rising clock edge.  OVF_CNT checks are
// only compiled when UART_ECHO_OVF_CNT_EN is defined.
module tb_uart_echo_fifo;

    logic        sysclk;
    logic        reset_n;
    logic        RX_STATUS;
    logic [7:0]  RX_DATA;
    logic        TX_STATUS;
    logic [1:0]  MODE;
    logic        CLR_OVF;
    logic [7:0]  TX_DATA;
    logic        TX_EN;
    logic [2:0]  FIFO_COUNT;
    logic        OVERFLOW;
`ifdef UART_ECHO_OVF_CNT_EN
    logic [7:0]  OVF_CNT;
`endif

    int checks = 0;
    int errors = 0;

    uart_echo_fifo #(
        .DATA_W (8),
        .DEPTH  (4)
    ) dut (
        .sysclk     (sysclk),
        .reset_n    (reset_n),
        .RX_STATUS  (RX_STATUS),
        .RX_DATA    (RX_DATA),
        .TX_STATUS  (TX_STATUS),
        .MODE       (MODE),
        .CLR_OVF    (CLR_OVF),
        .TX_DATA    (TX_DATA),
        .TX_EN      (TX_EN),
        .FIFO_COUNT (FIFO_COUNT),
        .OVERFLOW   (OVERFLOW)
`ifdef UART_ECHO_OVF_CNT_EN
        ,
        .OVF_CNT    (OVF_CNT)
`endif
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    // One receiver character: rising edge registered at the first edge, then
    // RX_STATUS low for a cycle.  MODE and RX_DATA are scrambled right after the
    // push edge to show queued characters keep their enqueue-time transform.
    task automatic push(input logic [7:0] d, input logic [1:0] m, input bit quiet);
        RX_DATA   = d;
        MODE      = m;
        RX_STATUS = 1'b1;
        tick();
        RX_STATUS = 1'b0;
        MODE      = ~m;
        RX_DATA   = ~d;
        tick();
        if (!quiet) $display("push data=%02h mode=%0d count=%0d", d, m, FIFO_COUNT);
    endtask

    initial begin
        logic [7:0] exp_q [$];

        reset_n   = 1'b0;
        RX_STATUS = 1'b0;
        RX_DATA   = 8'h00;
        TX_STATUS = 1'b0;
        MODE      = 2'd0;
        CLR_OVF   = 1'b0;

        // ---------------- reset state ----------------
        tick();
        tick();
        check("rst_tx_en",    TX_EN,      0);
        check("rst_tx_data",  TX_DATA,    0);
        check("rst_count",    FIFO_COUNT, 0);
        check("rst_overflow", OVERFLOW,   0);
`ifdef UART_ECHO_OVF_CNT_EN
        check("rst_ovf_cnt",  OVF_CNT,    0);
`endif
        reset_n = 1'b1;
        tick();

        // ---------------- MODE 1 transform and latency ----------------
        TX_STATUS = 1'b1;
        MODE      = 2'd1;
        RX_DATA   = 8'hC5;
        RX_STATUS = 1'b1;
        tick();                                  // push edge k
        check("lat_k_tx_en", TX_EN, 0);
        check("lat_k_count", FIFO_COUNT, 1);
        RX_STATUS = 1'b0;
        tick();                                  // edge k+1
        check("m1_c5_tx_en",  TX_EN,   1);
        check("m1_c5_data",   TX_DATA, 8'h3A);
        check("m1_c5_count",  FIFO_COUNT, 0);
        $display("tx data=%02h", TX_DATA);
        RX_DATA   = 8'h41;
        RX_STATUS = 1'b1;
        tick();                                  // TX_EN drops, push of 0x41
        check("m1_c5_tx_en_low", TX_EN,   0);
        check("m1_c5_hold",      TX_DATA, 8'h3A);
        RX_STATUS = 1'b0;
        tick();
        check("m1_41_tx_en", TX_EN,   1);
        check("m1_41_data",  TX_DATA, 8'h41);
        $display("tx data=%02h", TX_DATA);
        tick();
        check("m1_41_tx_en_low", TX_EN, 0);

        // ---------------- MODE 3 / MODE 2, MODE changed after push ----------------
        TX_STATUS = 1'b0;
        push(8'h01, 2'd3, 1'b0);
        push(8'h0F, 2'd2, 1'b0);
        check("m23_count", FIFO_COUNT, 2);
        MODE      = 2'd0;
        TX_STATUS = 1'b1;
        tick();
        check("m3_tx_en", TX_EN,   1);
        check("m3_data",  TX_DATA, 8'h80);
        $display("tx data=%02h", TX_DATA);
        tick();
        check("m3_gap", TX_EN, 0);
        tick();
        check("m2_tx_en", TX_EN,   1);
        check("m2_data",  TX_DATA, 8'hF0);
        $display("tx data=%02h", TX_DATA);
        tick();
        check("m2_gap",   TX_EN,      0);
        check("m2_empty", FIFO_COUNT, 0);

        // ---------------- overflow with DEPTH=4 ----------------
        TX_STATUS = 1'b0;
        for (int i = 1; i <= 4; i++) push(8'(i), 2'd0, 1'b0);
        check("full_count",       FIFO_COUNT, 4);
        check("full_no_overflow", OVERFLOW,   0);
        push(8'h05, 2'd0, 1'b0);
        check("ovf_count",    FIFO_COUNT, 4);
        check("ovf_overflow", OVERFLOW,   1);
`ifdef UART_ECHO_OVF_CNT_EN
        check("ovf_cnt_one", OVF_CNT, 1);
`endif
        TX_STATUS = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            check("drain_tx_en", TX_EN,   1);
            check("drain_data",  TX_DATA, 32'(i));
            $display("tx data=%02h", TX_DATA);
            tick();
            check("drain_gap", TX_EN, 0);
        end
        tick();
        check("drain_no_extra", TX_EN,      0);
        check("drain_empty",    FIFO_COUNT, 0);
        check("ovf_sticky",     OVERFLOW,   1);
        CLR_OVF = 1'b1;
        tick();
        CLR_OVF = 1'b0;
        check("clr_overflow", OVERFLOW, 0);
`ifdef UART_ECHO_OVF_CNT_EN
        check("clr_ovf_cnt", OVF_CNT, 0);
`endif

        // ---------------- full FIFO, push coincident with pop ----------------
        TX_STATUS = 1'b0;
        for (int i = 0; i < 4; i++) push(8'h11 + 8'(i), 2'd0, 1'b0);
        check("cpp_full", FIFO_COUNT, 4);
        RX_DATA   = 8'h15;
        MODE      = 2'd0;
        RX_STATUS = 1'b1;
        TX_STATUS = 1'b1;
        tick();
        RX_STATUS = 1'b0;
        check("cpp_count",    FIFO_COUNT, 4);
        check("cpp_overflow", OVERFLOW,   0);
        check("cpp_tx_en",    TX_EN,      1);
        check("cpp_data",     TX_DATA,    8'h11);
        $display("tx data=%02h", TX_DATA);
        exp_q = '{8'h12, 8'h13, 8'h14, 8'h15};
        foreach (exp_q[j]) begin
            tick();
            check("cpp_gap", TX_EN, 0);
            tick();
            check("cpp_drain_tx_en", TX_EN,   1);
            check("cpp_drain_data",  TX_DATA, exp_q[j]);
            $display("tx data=%02h", TX_DATA);
        end
        tick();
        check("cpp_empty", FIFO_COUNT, 0);

        // ---------------- reset mid-stream ----------------
        TX_STATUS = 1'b0;
        push(8'h21, 2'd0, 1'b0);
        push(8'h22, 2'd0, 1'b0);
        push(8'h23, 2'd0, 1'b0);
        check("mid_count", FIFO_COUNT, 3);
        TX_STATUS = 1'b1;
        tick();
        check("mid_tx_en", TX_EN,   1);
        check("mid_data",  TX_DATA, 8'h21);
        #2;
        reset_n = 1'b0;
        #1;
        check("async_tx_en",   TX_EN,      0);
        check("async_count",   FIFO_COUNT, 0);
        check("async_tx_data", TX_DATA,    0);
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stale_tx_en", TX_EN,      0);
            check("stale_count", FIFO_COUNT, 0);
        end

        // RX_STATUS already high when reset releases counts as a new character.
        reset_n   = 1'b0;
        TX_STATUS = 1'b0;
        MODE      = 2'd0;
        RX_DATA   = 8'h5A;
        RX_STATUS = 1'b1;
        tick();
        reset_n = 1'b1;
        tick();
        check("rel_push_count", FIFO_COUNT, 1);
        RX_STATUS = 1'b0;
        TX_STATUS = 1'b1;
        tick();
        check("rel_tx_en", TX_EN,   1);
        check("rel_data",  TX_DATA, 8'h5A);
        $display("tx data=%02h", TX_DATA);
        tick();

        // ---------------- drop with simultaneous clear, saturation ----------------
        TX_STATUS = 1'b0;
        for (int i = 0; i < 4; i++) push(8'h30 + 8'(i), 2'd0, 1'b0);
        RX_DATA   = 8'h34;
        RX_STATUS = 1'b1;
        CLR_OVF   = 1'b1;
        tick();
        RX_STATUS = 1'b0;
        CLR_OVF   = 1'b0;
        check("dc_overflow", OVERFLOW,   1);
        check("dc_count",    FIFO_COUNT, 4);
`ifdef UART_ECHO_OVF_CNT_EN
        check("dc_ovf_cnt",  OVF_CNT,    1);
`endif
        tick();
        for (int i = 0; i < 300; i++) push(8'(i), 2'd0, 1'b1);
        $display("drop burst of 300 characters done");
        check("sat_overflow", OVERFLOW,   1);
        check("sat_count",    FIFO_COUNT, 4);
`ifdef UART_ECHO_OVF_CNT_EN
        check("sat_ovf_cnt",  OVF_CNT,    255);
`endif
        CLR_OVF = 1'b1;
        tick();
        CLR_OVF = 1'b0;
        check("final_clr_overflow", OVERFLOW, 0);
`ifdef UART_ECHO_OVF_CNT_EN
        check("final_clr_ovf_cnt",  OVF_CNT,  0);
`endif
        // Queued contents survive the drop burst unchanged.
        TX_STATUS = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            check("post_drop_data", TX_DATA, 8'h30 + 8'(i));
            $display("tx data=%02h", TX_DATA);
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
